// File: rtl/fpmul_pkg.sv
// Shared constants and state encoding for the FP multiplier sequencer.
package fpmul_pkg;

    localparam logic [1:0] ADDR_A    = 2'd0;
    localparam logic [1:0] ADDR_B    = 2'd1;
    localparam logic [1:0] ADDR_CTRL = 2'd2;
    localparam logic [1:0] ADDR_RES  = 2'd3;

    localparam int BIT_DONE = 0;
    localparam int BIT_GO   = 0;
    localparam int BIT_BUSY = 1;
    localparam int BIT_ERR  = 2;
    localparam int BIT_IE   = 3;

    localparam int MUL_LAT_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

endpackage

// File: rtl/fpmul_ctrl_if.sv
// Register-slot bus between the processor data-memory port and the sequencer.
interface fpmul_ctrl_if #(
    parameter int WIDTH = 32
);
    // Single-cycle bus: a write is taken on every rising edge with we=1, no stall;
    // rd is combinational from address and valid in the same cycle.
    logic             we;
    logic [1:0]       address;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] rd;

    modport master (output we, address, wd, input rd);
    modport slave  (input we, address, wd, output rd);
endinterface

// File: rtl/fpmul_lat_counter.sv
// Loadable down-counter with zero flag, used to time the multiplier pipeline.
module fpmul_lat_counter
    import fpmul_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/fpmul_ctrl.sv
// Memory-mapped sequencer for the pipelined FP multiplier.
// Optional interrupt output and CTRL.ie bit are built when FPMUL_IRQ_EN is defined.
module fpmul_ctrl
    import fpmul_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    fpmul_ctrl_if.slave      bus,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic             mul_start,
    input  logic [WIDTH-1:0] mul_y,
    output logic             busy,
`ifdef FPMUL_IRQ_EN
    output logic             irq,
`endif
    output state_t           o_dbg_state
);

    localparam int CW = $clog2(MUL_LAT + 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_done;
    logic             r_err;
    logic             r_ie;
    logic             w_ctrl_wr;
    logic             w_go_req;
    logic             w_go_accept;
    logic             w_go_reject;
    logic             w_clr_err;
    logic             w_load;
    logic             w_dec;
    logic             w_zero;
    logic [WIDTH-1:0] w_status;

    assign w_ctrl_wr = bus.we && (bus.address == ADDR_CTRL);
    assign w_go_req  = w_ctrl_wr && bus.wd[BIT_GO];
    assign w_clr_err = w_ctrl_wr && bus.wd[BIT_ERR];
    // CAPTURE is the last busy cycle, so a GO landing on the capture edge chains directly.
    assign w_go_accept = w_go_req && ((r_state == ST_IDLE) || (r_state == ST_CAPTURE));
    assign w_go_reject = w_go_req && !w_go_accept;

    fpmul_lat_counter #(.W(CW)) u_lat (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (CW'(MUL_LAT - 1)),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        mul_start    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_go_accept) w_state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                mul_start    = 1'b1;
                w_load       = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_zero) w_state_next = ST_CAPTURE;
                else        w_dec        = 1'b1;
            end
            ST_CAPTURE: begin
                w_state_next = w_go_accept ? ST_ISSUE : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (bus.we && (r_state == ST_IDLE) && (bus.address == ADDR_A)) r_a <= bus.wd;
            if (bus.we && (r_state == ST_IDLE) && (bus.address == ADDR_B)) r_b <= bus.wd;
            if (r_state == ST_CAPTURE) r_result <= mul_y;
            // A chained GO on the capture edge leaves done low: the new run owns it.
            if (w_go_accept)                r_done <= 1'b0;
            else if (r_state == ST_CAPTURE) r_done <= 1'b1;
            if (w_go_reject)    r_err <= 1'b1;
            else if (w_clr_err) r_err <= 1'b0;
        end
    end

`ifdef FPMUL_IRQ_EN
    logic r_irq;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ie  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_ie <= bus.wd[BIT_IE];
            r_irq <= r_done && r_ie;
        end
    end
    assign irq = r_irq;
`else
    assign r_ie = 1'b0;
`endif

    assign busy        = (r_state == ST_WAIT) || (r_state == ST_CAPTURE);
    assign mul_a       = r_a;
    assign mul_b       = r_b;
    assign o_dbg_state = r_state;

    always_comb begin
        w_status           = '0;
        w_status[BIT_DONE] = r_done;
        w_status[BIT_BUSY] = busy;
        w_status[BIT_ERR]  = r_err;
        w_status[BIT_IE]   = r_ie;
    end

    always_comb begin
        case (bus.address)
            ADDR_A:    bus.rd = r_a;
            ADDR_B:    bus.rd = r_b;
            ADDR_CTRL: bus.rd = w_status;
            default:   bus.rd = r_result;
        endcase
    end

endmodule
